// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the three-port memory arbiter.
// Handshake: a requester raises req[i] with we[i]/addr_i/wdata_i stable and holds it
// until ack[i] pulses for one cycle; rdata and err are valid only during that pulse.
// A req still high on the cycle after the ack is taken as a new transaction.
interface mem_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [17:0] addr0;
  logic [17:0] addr1;
  logic [17:0] addr2;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic [31:0] wdata2;
  logic [2:0]  ack;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2,
    input  ack, rdata, err
  );

  modport slave (
    input  req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2,
    output ack, rdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising three requesters onto the single-word port of the
// SRAM-emulation memory manager, with a stall watchdog on each transaction.
module mem_arbiter #(
  parameter bit PRIO0          = 1'b0,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  mem_arbiter_if.slave bus,
  output logic        timeout_err,
  output logic        mem_wren,
  output logic [17:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_pause,
  output logic [1:0]  dbg_state,
  output logic [1:0]  dbg_grant
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  localparam logic [9:0] TMO = 10'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [1:0]  last_grant_q;
  logic [1:0]  last12_q;
  logic [1:0]  grant_q;
  logic        cmd_we_q;
  logic [17:0] cmd_addr_q;
  logic [31:0] cmd_wdata_q;
  logic [9:0]  cnt_q;
  logic [9:0]  cnt_inc;
  logic        tmo_q;
  logic [2:0]  ack_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [2:0]  sel;
  logic        win_valid;
  logic [1:0]  win_idx;
  logic [2:0]  req_hi;
  logic        wait_done;
  logic        wait_timeout;

  // Returns {found, port}: first requesting port in the order a, b, c.
  function automatic logic [2:0] pick(input logic [2:0] r, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] c);
    if (r[a])      return {1'b1, a};
    else if (r[b]) return {1'b1, b};
    else if (r[c]) return {1'b1, c};
    else           return 3'b000;
  endfunction

  assign req_hi = {bus.req[2:1], 1'b0};

  always_comb begin
    sel = 3'b000;
    if (PRIO0) begin
      // Port 0 pre-empts; ports 1/2 keep their own rotation pointer.
      if (bus.req[0])             sel = 3'b100;
      else if (last12_q == 2'd1)  sel = pick(req_hi, 2'd2, 2'd1, 2'd1);
      else                        sel = pick(req_hi, 2'd1, 2'd2, 2'd2);
    end else begin
      case (last_grant_q)
        2'd0:    sel = pick(bus.req, 2'd1, 2'd2, 2'd0);
        2'd1:    sel = pick(bus.req, 2'd2, 2'd0, 2'd1);
        default: sel = pick(bus.req, 2'd0, 2'd1, 2'd2);
      endcase
    end
  end

  assign win_valid    = sel[2];
  assign win_idx      = sel[1:0];
  assign cnt_inc      = cnt_q + 10'd1;
  assign wait_done    = !mem_pause;
  assign wait_timeout = mem_pause && (cnt_inc == TMO);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_valid) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (wait_done || wait_timeout) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 2'd2;
      last12_q     <= 2'd2;
      grant_q      <= 2'd0;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= 18'd0;
      cmd_wdata_q  <= 32'd0;
      cnt_q        <= 10'd0;
      tmo_q        <= 1'b0;
      ack_q        <= 3'b000;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
      timeout_err  <= 1'b0;
      mem_wren     <= 1'b0;
      mem_addr     <= 18'd0;
      mem_wdata    <= 32'd0;
    end else begin
      ack_q <= 3'b000;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_valid) begin
            grant_q  <= win_idx;
            cmd_we_q <= bus.we[win_idx];
            case (win_idx)
              2'd0: begin
                cmd_addr_q  <= bus.addr0;
                cmd_wdata_q <= bus.wdata0;
              end
              2'd1: begin
                cmd_addr_q  <= bus.addr1;
                cmd_wdata_q <= bus.wdata1;
              end
              default: begin
                cmd_addr_q  <= bus.addr2;
                cmd_wdata_q <= bus.wdata2;
              end
            endcase
          end
        end
        S_ISSUE: begin
          mem_wren  <= cmd_we_q;
          mem_addr  <= cmd_addr_q;
          mem_wdata <= cmd_wdata_q;
          cnt_q     <= 10'd0;
          tmo_q     <= 1'b0;
        end
        S_WAIT: begin
          if (wait_done) begin
            rdata_q  <= cmd_we_q ? cmd_wdata_q : mem_rdata;
            mem_wren <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
            if (wait_timeout) begin
              tmo_q       <= 1'b1;
              timeout_err <= 1'b1;
              rdata_q     <= 32'd0;
              mem_wren    <= 1'b0;
            end
          end
        end
        S_ACK: begin
          // ack/err are registered here so they land together on the following cycle.
          ack_q        <= 3'b001 << grant_q;
          err_q        <= tmo_q;
          last_grant_q <= grant_q;
          if (grant_q != 2'd0) last12_q <= grant_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign dbg_state = state_q;
  assign dbg_grant = last_grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance (a) and port-0-priority instance (b).
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_arbiter_if bus_a();
  mem_arbiter_if bus_b();

  logic        timeout_err_a, mem_wren_a, mem_pause_a;
  logic [17:0] mem_addr_a;
  logic [31:0] mem_wdata_a, mem_rdata_a;
  logic [1:0]  dbg_state_a, dbg_grant_a;
  logic        timeout_err_b, mem_wren_b, mem_pause_b;
  logic [17:0] mem_addr_b;
  logic [31:0] mem_wdata_b, mem_rdata_b;
  logic [1:0]  dbg_state_b, dbg_grant_b;

  mem_arbiter #(.PRIO0(1'b0), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .timeout_err(timeout_err_a),
    .mem_wren(mem_wren_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .mem_pause(mem_pause_a),
    .dbg_state(dbg_state_a), .dbg_grant(dbg_grant_a)
  );

  mem_arbiter #(.PRIO0(1'b1), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .timeout_err(timeout_err_b),
    .mem_wren(mem_wren_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .mem_pause(mem_pause_b),
    .dbg_state(dbg_state_b), .dbg_grant(dbg_grant_b)
  );

  int checks = 0;
  int errors = 0;
  int lat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the selected instance shows an ack; lat = cycles after the sampling edge.
  task automatic wait_ack(input bit sel_b, input int budget, output int lat_o);
    int i;
    lat_o = -1;
    i = 0;
    while (lat_o < 0 && i < budget) begin
      step();
      i++;
      if ((sel_b ? bus_b.ack : bus_a.ack) != 3'b000) lat_o = i - 1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset_n = 1'b0;
    bus_a.req = '0; bus_a.we = '0;
    bus_a.addr0 = '0; bus_a.addr1 = '0; bus_a.addr2 = '0;
    bus_a.wdata0 = '0; bus_a.wdata1 = '0; bus_a.wdata2 = '0;
    bus_b.req = '0; bus_b.we = '0;
    bus_b.addr0 = '0; bus_b.addr1 = '0; bus_b.addr2 = '0;
    bus_b.wdata0 = '0; bus_b.wdata1 = '0; bus_b.wdata2 = '0;
    mem_pause_a = 1'b0; mem_rdata_a = '0;
    mem_pause_b = 1'b0; mem_rdata_b = '0;

    repeat (2) step();
    chk("rst_state", dbg_state_a, 2'd0);
    chk("rst_grant", dbg_grant_a, 2'd2);
    chk("rst_ack", bus_a.ack, 3'b000);
    chk("rst_rdata", bus_a.rdata, 32'h0);
    chk("rst_err", bus_a.err, 1'b0);
    chk("rst_tmo_err", timeout_err_a, 1'b0);
    chk("rst_wren", mem_wren_a, 1'b0);
    chk("rst_addr", mem_addr_a, 18'h0);
    chk("rst_wdata", mem_wdata_a, 32'h0);
    reset_n = 1'b1;

    // Single read on port 1, no stall.
    bus_a.we = 3'b000; bus_a.addr1 = 18'h00123;
    mem_rdata_a = 32'hDEADBEEF; bus_a.req = 3'b010;
    step();
    chk("rd_issue_state", dbg_state_a, 2'd1);
    step();
    chk("rd_wait_state", dbg_state_a, 2'd2);
    chk("rd_mem_addr", mem_addr_a, 18'h00123);
    chk("rd_mem_wren", mem_wren_a, 1'b0);
    step();
    chk("rd_no_early_ack", bus_a.ack, 3'b000);
    step();
    chk("rd_ack", bus_a.ack, 3'b010);
    chk("rd_rdata", bus_a.rdata, 32'hDEADBEEF);
    chk("rd_err", bus_a.err, 1'b0);
    bus_a.req = 3'b000;
    step();
    chk("rd_ack_pulse", bus_a.ack, 3'b000);
    chk("rd_dbg_grant", dbg_grant_a, 2'd1);
    chk("rd_idle", dbg_state_a, 2'd0);

    // Write on port 0 with five stall cycles.
    bus_a.we = 3'b001; bus_a.wdata0 = 32'hF0806020; bus_a.addr0 = 18'h01000;
    mem_rdata_a = 32'h12345678; mem_pause_a = 1'b1; bus_a.req = 3'b001;
    step();
    step();
    chk("wr_wren_wait", mem_wren_a, 1'b1);
    chk("wr_mem_wdata", mem_wdata_a, 32'hF0806020);
    repeat (5) step();
    chk("wr_still_wait", dbg_state_a, 2'd2);
    chk("wr_wren_held", mem_wren_a, 1'b1);
    mem_pause_a = 1'b0;
    step();
    chk("wr_wren_drop", mem_wren_a, 1'b0);
    chk("wr_no_early_ack", bus_a.ack, 3'b000);
    step();
    chk("wr_ack", bus_a.ack, 3'b001);
    chk("wr_rdata", bus_a.rdata, 32'hF0806020);
    chk("wr_err", bus_a.err, 1'b0);
    bus_a.req = 3'b000; bus_a.we = 3'b000;

    // Fairness from the reset pointer with all ports held.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    bus_a.req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_ack(1'b0, 12, lat);
      chk("rr_lat", lat, 3);
      chk("rr_order", bus_a.ack, 3'b001 << (k % 3));
    end
    bus_a.req = 3'b000;

    // Port 0 priority: held req[0] wins every time, then 1/2 rotate.
    bus_b.req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      wait_ack(1'b1, 12, lat);
      chk("prio_lat", lat, 3);
      chk("prio_order", bus_b.ack, 3'b001);
    end
    bus_b.req = 3'b110;
    wait_ack(1'b1, 12, lat);
    chk("prio_p1", bus_b.ack, 3'b010);
    wait_ack(1'b1, 12, lat);
    chk("prio_p2", bus_b.ack, 3'b100);
    bus_b.req = 3'b000;

    // Timeout with mem_pause stuck high.
    bus_a.addr2 = 18'h2BEEF; mem_rdata_a = 32'hCAFEF00D;
    mem_pause_a = 1'b1; bus_a.req = 3'b100;
    wait_ack(1'b0, 20, lat);
    chk("tmo_lat", lat, 10);
    chk("tmo_ack", bus_a.ack, 3'b100);
    chk("tmo_err", bus_a.err, 1'b1);
    chk("tmo_rdata", bus_a.rdata, 32'h0);
    chk("tmo_sticky_set", timeout_err_a, 1'b1);
    bus_a.req = 3'b000;
    step();
    chk("tmo_err_pulse", bus_a.err, 1'b0);
    chk("tmo_sticky_hold", timeout_err_a, 1'b1);
    mem_pause_a = 1'b0;
    bus_a.addr1 = 18'h00042; mem_rdata_a = 32'h11112222; bus_a.req = 3'b010;
    wait_ack(1'b0, 12, lat);
    chk("post_tmo_lat", lat, 3);
    chk("post_tmo_rdata", bus_a.rdata, 32'h11112222);
    chk("post_tmo_err", bus_a.err, 1'b0);
    chk("post_tmo_sticky", timeout_err_a, 1'b1);
    bus_a.req = 3'b000;

    // Reset asserted mid-WAIT drops the transaction.
    bus_a.we = 3'b001; bus_a.wdata0 = 32'h55AA55AA; mem_pause_a = 1'b1;
    bus_a.req = 3'b001;
    step();
    step();
    chk("rstw_in_wait", dbg_state_a, 2'd2);
    chk("rstw_wren_pre", mem_wren_a, 1'b1);
    reset_n = 1'b0;
    bus_a.req = 3'b100;
    #1;
    chk("rstw_state", dbg_state_a, 2'd0);
    chk("rstw_wren", mem_wren_a, 1'b0);
    chk("rstw_ack", bus_a.ack, 3'b000);
    chk("rstw_tmo_clr", timeout_err_a, 1'b0);
    chk("rstw_grant", dbg_grant_a, 2'd2);
    step();
    chk("rstw_no_ack", bus_a.ack, 3'b000);
    reset_n = 1'b1;
    mem_pause_a = 1'b0; bus_a.we = 3'b000;
    bus_a.addr2 = 18'h00777; mem_rdata_a = 32'h0BADF00D;
    wait_ack(1'b0, 12, lat);
    chk("rstw_p2_lat", lat, 3);
    chk("rstw_p2_ack", bus_a.ack, 3'b100);
    chk("rstw_p2_rdata", bus_a.rdata, 32'h0BADF00D);
    bus_a.req = 3'b000;

    // Requester changes its command during WAIT; latched copy must be used.
    bus_a.we = 3'b000; bus_a.addr1 = 18'h00ABC; mem_pause_a = 1'b1;
    mem_rdata_a = 32'h600DD00D; bus_a.req = 3'b010;
    step();
    step();
    chk("stab_addr_wait", mem_addr_a, 18'h00ABC);
    bus_a.addr1 = 18'h3FFFF; bus_a.we = 3'b010; bus_a.wdata1 = 32'hFFFF0000;
    step();
    step();
    chk("stab_addr_hold", mem_addr_a, 18'h00ABC);
    chk("stab_wren_hold", mem_wren_a, 1'b0);
    mem_pause_a = 1'b0;
    wait_ack(1'b0, 12, lat);
    chk("stab_lat", lat, 1);
    chk("stab_ack", bus_a.ack, 3'b010);
    chk("stab_rdata", bus_a.rdata, 32'h600DD00D);
    bus_a.req = 3'b000;
    step();
    chk("stab_addr_idle", mem_addr_a, 18'h00ABC);
    chk("stab_idle", dbg_state_a, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Three-port round-robin arbiter that shares the single-word memory port of the SRAM-emulation memory manager (wren / address / write data / read data / pause) between independent user-logic requesters (e.g. camera frame writer, image-processing engine, host/UART access). It sits in the user clock domain, directly in front of the memory manager, and serialises requests so only one transaction is ever presented to the manager. A watchdog flags transactions that stall indefinitely.

## Interface
- PRIO0, 0: when 1, port 0 wins whenever it requests; ports 1/2 round-robin among themselves.
- TIMEOUT_CYCLES, 1023: WAIT-state cycles before a transaction is force-completed with error; counter is 10 bits.
- clk  in  1  user logic clock (same clock as the memory manager's clk_sync); one clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req[2:0]  in  3  per-port request; held high until that port's ack.
- we[2:0]  in  3  per-port write enable (1 = write, 0 = read); stable while req high.
- addr0/addr1/addr2  in  18 each  per-port word address.
- wdata0/wdata1/wdata2  in  32 each  per-port write data.
- ack[2:0]  out  3  one-cycle completion pulse, one-hot, to the granted port.
- rdata  out  32  read data (write data for writes), valid while any ack bit is high.
- err  out  1  high with ack when the transaction timed out.
- timeout_err  out  1  sticky; set on any timeout, cleared only by reset.
- mem_wren  out  1  to memory manager wren.
- mem_addr  out  18  to memory manager starting_address.
- mem_wdata  out  32  to memory manager data_write.
- mem_rdata  in  32  from memory manager data_read.
- mem_pause  in  1  from memory manager pause; high = transaction not yet complete.
- dbg_state  out  2  current state encoding; dbg_grant  out  2  last granted port.

## Operation
- States: IDLE(0), ISSUE(1), WAIT(2), ACK(3).
- IDLE: if any req, select winner, latch its we/addr/wdata into command registers, record grant, -> ISSUE; else stay; mem_wren=0.
- Selection: round-robin search starting at (last_grant+1) mod 3; with PRIO0=1, req[0] wins outright, else search over ports 1/2 only starting after last of them granted.
- ISSUE: drive mem_wren/mem_addr/mem_wdata from command registers; clear timeout counter; -> WAIT. Command outputs hold through WAIT.
- WAIT: if mem_pause=0, capture mem_rdata (reads) or command wdata (writes) into rdata register, -> ACK. Else increment counter; when counter reaches TIMEOUT_CYCLES, set err and timeout_err, rdata=32'h0, -> ACK.
- ACK: pulse ack[grant] for exactly one cycle, err valid same cycle; drop mem_wren to 0; update last_grant; -> IDLE.
- Requester must drop req in the cycle after ack; a req still high in IDLE is a new transaction and competes normally (pointer already advanced, so no port re-wins ahead of a waiting peer).
- mem_addr/mem_wdata hold their last values when idle (memory manager single-word cache then treats idle as a repeat read, no DDR traffic).
- Changes on req/we/addr/wdata of the granted port after IDLE are ignored (latched copy used).

## Timing
- Reset (async, immediate): state=IDLE, ack=0, rdata=0, err=0, timeout_err=0, mem_wren=0, mem_addr=0, mem_wdata=0, last_grant=2 (port 0 first), counter=0, dbg outputs 0/2.
- Minimum latency: req sampled high at edge N -> ISSUE after N, WAIT after N+1, ACK after N+2 if mem_pause=0 at edge N+2 -> ack high cycle N+3 to N+4.
- Each extra cycle of mem_pause high adds one cycle; max WAIT length TIMEOUT_CYCLES.
- Back-to-back: next grant sampled at edge after ACK; throughput one transaction per 4 cycles best case.
- Simultaneous: all three req in same cycle -> grants 0,1,2 in order (reset pointer); req arriving during ACK waits for IDLE.
- Reset asserted mid-transaction: transaction dropped, no ack issued; requester must re-request.

## Test plan
- Single read: req[1]=1, we=0, addr1=18'h00123, mem_pause=0, mem_rdata=32'hDEADBEEF -> mem_addr=18'h00123, mem_wren=0, ack=3'b010 and rdata=32'hDEADBEEF exactly 3 cycles after request sample.
- Write with stall: req[0], we=1, wdata0=32'hF0806020, mem_pause high 5 cycles -> mem_wren=1 held through WAIT, ack[0] 8 cycles after sample, rdata=32'hF0806020, err=0.
- Fairness: req=3'b111 held continuously (re-raised after each ack) -> ack order 0,1,2,0,1,2; with PRIO0=1 -> order 0,0,0 while req[0] stays high.
- Timeout: TIMEOUT_CYCLES=8, mem_pause stuck high -> ack with err=1, rdata=0, timeout_err stays 1 until reset_n low.
- Reset mid-WAIT: assert reset_n=0 during WAIT -> immediately state=IDLE, mem_wren=0, no ack; after release, pending req[2] granted first after port 0/1 absent.
- Command stability: change addr1 during WAIT -> mem_addr unchanged until ACK.
